// File: rtl/quantum_rr_scheduler_if.sv
// Process-side bus of the round-robin scheduler: ready/yield requests in,
// grant, status and switch counter out.
interface quantum_rr_scheduler_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned QW   = 4,
    parameter int unsigned CNTW = 8
);
    logic [N-1:0]    ready;
    logic            yield;
    logic [N-1:0]    grant;
    logic [IDW-1:0]  run_id;
    logic            running;
    logic            switch_pulse;
    logic [QW-1:0]   quantum_left;
    logic [CNTW-1:0] switch_count;

    modport master (
        output ready, yield,
        input  grant, run_id, running, switch_pulse, quantum_left, switch_count
    );

    modport slave (
        input  ready, yield,
        output grant, run_id, running, switch_pulse, quantum_left, switch_count
    );
endinterface

// File: rtl/quantum_rr_scheduler.sv
// Round-robin time-slice scheduler: one run slot shared by N processes,
// each slice lasting QUANTUM slow time-base ticks unless cut short.
module quantum_rr_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned QUANTUM = 4,
    parameter int unsigned QW      = 4,
    parameter int unsigned CNTW    = 8
) (
    input  logic                  cin,
    input  logic                  rst,
    input  logic                  slow_clk,
    quantum_rr_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            s1_q, s1_d, s2_q, s2_d, p_q, p_d;
    logic            tick_c;
    logic [IDW-1:0]  run_id_q, run_id_d;
    logic [IDW-1:0]  last_id_q, last_id_d;
    logic [IDW-1:0]  pick_id_c, cand_c;
    logic            pick_found_c;
    logic            slice_end_c;
    logic [QW-1:0]   quantum_left_q, quantum_left_d;
    logic [CNTW-1:0] switch_count_q, switch_count_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            running_q, running_d;
    logic            switch_pulse_q, switch_pulse_d;

    assign tick_c = s2_q & ~p_q;

    // Round-robin search starting just after the last granted index
    always_comb begin
        pick_id_c    = '0;
        pick_found_c = 1'b0;
        cand_c       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand_c = IDW'((32'(last_id_q) + i) % N);
            if (!pick_found_c && bus.ready[cand_c]) begin
                pick_id_c    = cand_c;
                pick_found_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        s1_d           = slow_clk;
        s2_d           = s1_q;
        p_d            = s2_q;
        run_id_d       = run_id_q;
        last_id_d      = last_id_q;
        quantum_left_d = quantum_left_q;
        switch_count_d = switch_count_q;
        slice_end_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    run_id_d       = pick_id_c;
                    last_id_d      = pick_id_c;
                    quantum_left_d = QW'(QUANTUM);
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (tick_c) begin
                    quantum_left_d = quantum_left_q - QW'(1);
                end
                slice_end_c = (tick_c && (quantum_left_q == QW'(1))) ||
                              bus.yield || !bus.ready[run_id_q];
                if (slice_end_c) begin
                    state_d        = SWITCH;
                    switch_count_d = (&switch_count_q) ? switch_count_q
                                                       : switch_count_q + CNTW'(1);
                end
            end
            SWITCH: begin
                if (pick_found_c) begin
                    run_id_d       = pick_id_c;
                    last_id_d      = pick_id_c;
                    quantum_left_d = QW'(QUANTUM);
                    state_d        = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        grant_d        = (state_d == RUN) ? (N'(1) << run_id_d) : '0;
        running_d      = (state_d == RUN);
        switch_pulse_d = (state_d == SWITCH);
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            state_q        <= IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            p_q            <= 1'b0;
            run_id_q       <= '0;
            last_id_q      <= IDW'(N - 1);
            quantum_left_q <= '0;
            switch_count_q <= '0;
            grant_q        <= '0;
            running_q      <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            p_q            <= p_d;
            run_id_q       <= run_id_d;
            last_id_q      <= last_id_d;
            quantum_left_q <= quantum_left_d;
            switch_count_q <= switch_count_d;
            grant_q        <= grant_d;
            running_q      <= running_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.run_id       = run_id_q;
    assign bus.running      = running_q;
    assign bus.switch_pulse = switch_pulse_q;
    assign bus.quantum_left = quantum_left_q;
    assign bus.switch_count = switch_count_q;

endmodule
